trace_capture_buffer: RTL and testbench

Parametrised hardware execution-trace buffer that captures per-retire records (PC, instruction, ALU/writeback result) from the RV32IM pipeline into a circular store. Captured records are read out oldest-first over a valid/ready port. Supports a PC-match trigger with a configurable post-trigger window and two fill modes, so the pipeline can be debugged in silicon without a simulator monitor. Sits beside the writeback stage; capture-side signals are tapped from the WB pipeline register.

---
 rtl/trace_pkg.sv | 34 +++
 rtl/trace_mem.sv | 28 ++
 rtl/trace_capture_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and record layout for the execution-trace capture buffer.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 16-bit timestamp to every record.
package trace_pkg;

    localparam int INSTR_W = 32;
    localparam int TS_W    = 16;

    // Buffer state, visible on the STATE port: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    // Packed record layout is {result, instr, pc[, ts]}; ts sits in the low bits
    function automatic int rec_width(input int xlen);
`ifdef TRACE_TIMESTAMP_EN
        return 2 * xlen + INSTR_W + TS_W;
`else
        return 2 * xlen + INSTR_W;
`endif
    endfunction

    // Bit offset of the PC field inside a packed record
    function automatic int pc_lo();
`ifdef TRACE_TIMESTAMP_EN
        return TS_W;
`else
        return 0;
`endif
    endfunction

endpackage

// File: rtl/trace_mem.sv
// Record store for the trace buffer: one synchronous write port and one
// asynchronous read port so the read side can present a record in the same
// cycle its address changes.
module trace_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write one record per enabled cycle; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Execution-trace capture buffer: records retire events from the WB stage into
// a circular store, stops after a PC trigger plus a post-trigger window (or
// when full in stop-full mode), then drains oldest-first over valid/ready.
// Optional feature macro: TRACE_TIMESTAMP_EN (adds RD_TIMESTAMP and a
// free-running 16-bit cycle counter stored with every record).
//
// Read handshake: a record is transferred on every rising CLK edge where
// RD_VALID and RD_READY are both high. RD_VALID only rises in FROZEN, never
// depends on RD_READY, and while RD_VALID is high and RD_READY low the RD_*
// fields hold stable.
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 4,
    parameter int STOP_FULL  = 0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       ARM,
    input  logic                       CLEAR,
    input  logic                       CAP_VALID,
    input  logic [XLEN-1:0]            CAP_PC,
    input  logic [31:0]                CAP_INSTR,
    input  logic [XLEN-1:0]            CAP_RESULT,
    input  logic                       TRIG_EN,
    input  logic [XLEN-1:0]            TRIG_PC,
    input  logic                       RD_READY,
    output logic                       RD_VALID,
    output logic [XLEN-1:0]            RD_PC,
    output logic [31:0]                RD_INSTR,
    output logic [XLEN-1:0]            RD_RESULT,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            RD_TIMESTAMP,
`endif
    output logic                       RD_LAST,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic [1:0]                 STATE,
    output logic                       OVERFLOW
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int RW    = rec_width(XLEN);
    localparam int PC_LO = pc_lo();

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST_DEPTH);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t         state;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  post_cnt;
    logic           overflow;

    logic           in_capture;
    logic           full;
    logic           cap_take;
    logic           trig_hit;
    logic [CW-1:0]  count_after_cap;
    logic           freeze_full;
    logic           pop;

    logic [RW-1:0]  wdata;
    logic [RW-1:0]  rdata;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    // Free-running cycle counter; wraps naturally at 0xFFFF
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wdata        = {CAP_RESULT, CAP_INSTR, CAP_PC, ts};
    assign RD_TIMESTAMP = rdata[TS_W-1:0];
`else
    assign wdata = {CAP_RESULT, CAP_INSTR, CAP_PC};
`endif

    // Capture-side decode. In stop-full mode a full buffer refuses new records;
    // in overwrite mode a full buffer keeps accepting and drops the oldest.
    always_comb begin
        in_capture      = (state == ARMED) || (state == POST);
        full            = (count == FULL_CNT);
        cap_take        = in_capture && CAP_VALID && !((STOP_FULL != 0) && full);
        trig_hit        = (state == ARMED) && CAP_VALID && TRIG_EN && (CAP_PC == TRIG_PC);
        count_after_cap = full ? count : count + ONE;
        freeze_full     = (STOP_FULL != 0) && (count_after_cap == FULL_CNT);
    end

    // Oldest record sits COUNT entries behind the write pointer; with
    // COUNT==DEPTH the low bits are zero and rd_ptr equals wr_ptr, as wanted.
    assign rd_ptr   = wr_ptr - count[AW-1:0];
    assign RD_VALID = (state == FROZEN) && (count != '0);
    assign RD_LAST  = RD_VALID && (count == ONE);
    assign pop      = RD_VALID && RD_READY;

    assign RD_PC     = rdata[PC_LO +: XLEN];
    assign RD_INSTR  = rdata[PC_LO + XLEN +: INSTR_W];
    assign RD_RESULT = rdata[PC_LO + XLEN + INSTR_W +: XLEN];

    assign COUNT    = count;
    assign STATE    = state;
    assign OVERFLOW = overflow;

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_mem (
        .CLK   (CLK),
        .we    (cap_take),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Capture/readout FSM with pointers, occupancy, post window and overflow flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            overflow <= 1'b0;
        end else if (CLEAR) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARM) begin
                        state    <= ARMED;
                        count    <= '0;
                        post_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end

                ARMED: begin
                    if (cap_take) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count_after_cap;
                        if (full) begin
                            overflow <= 1'b1;
                        end
                        if (freeze_full) begin
                            state <= FROZEN;
                        end else if (trig_hit) begin
                            if (POST_DEPTH == 0) begin
                                state <= FROZEN;
                            end else begin
                                state    <= POST;
                                post_cnt <= POST_LOAD;
                            end
                        end
                    end
                end

                POST: begin
                    if (cap_take) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        count    <= count_after_cap;
                        post_cnt <= post_cnt - ONE;
                        if (full) begin
                            overflow <= 1'b1;
                        end
                        if (freeze_full || (post_cnt == ONE)) begin
                            state <= FROZEN;
                        end
                    end
                end

                FROZEN: begin
                    if (count == '0) begin
                        state <= IDLE;
                    end else if (pop) begin
                        count <= count - ONE;
                        if (count == ONE) begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Self-checking bench for trace_capture_buffer. Three instances share the
// capture-side stimulus: [0] POST_DEPTH=2 overwrite, [1] POST_DEPTH=0
// overwrite, [2] POST_DEPTH=4 stop-full. Each has its own RD_READY.
module tb_trace_capture_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic              CLK;
    logic              RESET;
    logic              arm;
    logic              clear;
    logic              cap_valid;
    logic [XLEN-1:0]   cap_pc;
    logic [31:0]       cap_instr;
    logic [XLEN-1:0]   cap_result;
    logic              trig_en;
    logic [XLEN-1:0]   trig_pc;
    logic              rd_ready  [3];
    logic              rd_valid  [3];
    logic [XLEN-1:0]   rd_pc     [3];
    logic [31:0]       rd_instr  [3];
    logic [XLEN-1:0]   rd_result [3];
    logic              rd_last   [3];
    logic [4:0]        count     [3];
    logic [1:0]        state     [3];
    logic              overflow  [3];
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]       rd_ts     [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic [4:0]  cnt;
    } cap_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        last;
    } rd_vec_t;

    cap_vec_t cv [7];
    rd_vec_t  rv [7];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        trace_capture_buffer #(
            .XLEN       (XLEN),
            .DEPTH      (DEPTH),
            .POST_DEPTH (g == 0 ? 2 : (g == 1 ? 0 : 4)),
            .STOP_FULL  (g == 2 ? 1 : 0)
        ) u_dut (
            .CLK          (CLK),
            .RESET        (RESET),
            .ARM          (arm),
            .CLEAR        (clear),
            .CAP_VALID    (cap_valid),
            .CAP_PC       (cap_pc),
            .CAP_INSTR    (cap_instr),
            .CAP_RESULT   (cap_result),
            .TRIG_EN      (trig_en),
            .TRIG_PC      (trig_pc),
            .RD_READY     (rd_ready[g]),
            .RD_VALID     (rd_valid[g]),
            .RD_PC        (rd_pc[g]),
            .RD_INSTR     (rd_instr[g]),
            .RD_RESULT    (rd_result[g]),
`ifdef TRACE_TIMESTAMP_EN
            .RD_TIMESTAMP (rd_ts[g]),
`endif
            .RD_LAST      (rd_last[g]),
            .COUNT        (count[g]),
            .STATE        (state[g]),
            .OVERFLOW     (overflow[g])
        );
    end

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] result_of(input logic [31:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic cap(input logic [31:0] pc);
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_instr  = instr_of(pc);
        cap_result = result_of(pc);
        tick();
        cap_valid  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk_rec(input int u, input string name, input logic [31:0] pc);
        chk({name, "_pc"},     rd_pc[u],     pc);
        chk({name, "_instr"},  rd_instr[u],  instr_of(pc));
        chk({name, "_result"}, rd_result[u], result_of(pc));
    endtask

    initial begin
        RESET      = 1'b0;
        arm        = 1'b0;
        clear      = 1'b0;
        cap_valid  = 1'b0;
        cap_pc     = '0;
        cap_instr  = '0;
        cap_result = '0;
        trig_en    = 1'b0;
        trig_pc    = '0;
        for (int i = 0; i < 3; i++) rd_ready[i] = 1'b0;

        // Trigger-window capture table for instance 0 (POST_DEPTH=2, TRIG_PC=0x10)
        cv[0] = '{32'h00, 2'd1, 5'd1};
        cv[1] = '{32'h04, 2'd1, 5'd2};
        cv[2] = '{32'h08, 2'd1, 5'd3};
        cv[3] = '{32'h0C, 2'd1, 5'd4};
        cv[4] = '{32'h10, 2'd2, 5'd5};
        cv[5] = '{32'h14, 2'd2, 5'd6};
        cv[6] = '{32'h18, 2'd3, 5'd7};
        for (int i = 0; i < 7; i++) rv[i] = '{32'(4 * i), (i == 6)};

        // ---- 1. reset ----
        repeat (2) @(posedge CLK);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("rst_state", 32'(state[u]), 32'd0);
            chk("rst_count", 32'(count[u]), 32'd0);
            chk("rst_valid", 32'(rd_valid[u]), 32'd0);
            chk("rst_last",  32'(rd_last[u]), 32'd0);
            chk("rst_ovf",   32'(overflow[u]), 32'd0);
        end
        RESET = 1'b1;
        tick();
        cap(32'h40);
        cap(32'h44);
        chk("idle_cap_count", 32'(count[0]), 32'd0);
        chk("idle_cap_state", 32'(state[0]), 32'd0);

        // ---- 2. trigger window ----
        trig_en = 1'b1;
        trig_pc = 32'h10;
        do_arm();
        chk("arm_state", 32'(state[0]), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cap(cv[i].pc);
            chk("win_state", 32'(state[0]), 32'(cv[i].st));
            chk("win_count", 32'(count[0]), 32'(cv[i].cnt));
        end
        cap(32'h1C);
        chk("win_frozen_drop", 32'(count[0]), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk("win_rd_valid", 32'(rd_valid[0]), 32'd1);
            chk_rec(0, "win_rd", rv[i].pc);
            chk("win_rd_last", 32'(rd_last[0]), 32'(rv[i].last));
            rd_ready[0] = 1'b1;
            tick();
        end
        rd_ready[0] = 1'b0;
        chk("win_end_state", 32'(state[0]), 32'd0);
        chk("win_end_valid", 32'(rd_valid[0]), 32'd0);

        // ---- 3. wrap with overwrite, POST_DEPTH=0 ----
        do_clear();
        trig_pc = 32'h4C;
        do_arm();
        for (int i = 0; i < 20; i++) begin
            cap(32'(4 * i));
            if (i == 18) chk("wrap_armed", 32'(state[1]), 32'd1);
        end
        chk("wrap_state", 32'(state[1]), 32'd3);
        chk("wrap_count", 32'(count[1]), 32'd16);
        chk("wrap_ovf",   32'(overflow[1]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk_rec(1, "wrap_rd", 32'h10 + 32'(4 * i));
            chk("wrap_rd_last", 32'(rd_last[1]), 32'(i == 15));
            rd_ready[1] = 1'b1;
            tick();
        end
        rd_ready[1] = 1'b0;
        chk("wrap_idle", 32'(state[1]), 32'd0);
        chk("wrap_ovf_kept", 32'(overflow[1]), 32'd1);
        do_arm();
        chk("wrap_arm_clr_ovf", 32'(overflow[1]), 32'd0);

        // ---- 4. stop-full ----
        do_clear();
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 17; i++) begin
            cap(32'h100 + 32'(4 * i));
            if (i == 14) chk("stop_armed", 32'(state[2]), 32'd1);
            if (i == 15) chk("stop_frozen16", 32'(state[2]), 32'd3);
        end
        chk("stop_count", 32'(count[2]), 32'd16);
        chk("stop_ovf",   32'(overflow[2]), 32'd0);

        // ---- 5. backpressure then drain ----
        for (int i = 0; i < 3; i++) begin
            chk_rec(2, "bp_hold", 32'h100);
            chk("bp_count", 32'(count[2]), 32'd16);
            tick();
        end
        rd_ready[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_rec(2, "stop_rd", 32'h100 + 32'(4 * i));
            tick();
            chk("stop_pop_count", 32'(count[2]), 32'(15 - i));
        end
        rd_ready[2] = 1'b0;
        chk("stop_idle", 32'(state[2]), 32'd0);

        // ---- 6. CLEAR mid-POST, then restart ----
        do_clear();
        trig_en = 1'b1;
        trig_pc = 32'h08;
        do_arm();
        cap(32'h00);
        cap(32'h04);
        cap(32'h08);
        chk("clr_in_post", 32'(state[0]), 32'd2);
        clear = 1'b1;
        arm   = 1'b1;
        tick();
        clear = 1'b0;
        arm   = 1'b0;
        chk("clr_state", 32'(state[0]), 32'd0);
        chk("clr_count", 32'(count[0]), 32'd0);
        chk("clr_valid", 32'(rd_valid[0]), 32'd0);
        trig_pc = 32'h204;
        do_arm();
        cap(32'h200);
        cap(32'h204);
        cap(32'h208);
        cap(32'h20C);
        chk("restart_state", 32'(state[0]), 32'd3);
        chk("restart_count", 32'(count[0]), 32'd4);
        chk_rec(0, "restart_rd0", 32'h200);

        // ---- asynchronous reset mid-readout ----
        rd_ready[0] = 1'b1;
        tick();
        rd_ready[0] = 1'b0;
        chk("pre_rst_count", 32'(count[0]), 32'd3);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_state", 32'(state[0]), 32'd0);
        chk("arst_count", 32'(count[0]), 32'd0);
        chk("arst_valid", 32'(rd_valid[0]), 32'd0);
        tick();
        RESET = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
